tdm_demux_4: RTL

Four-channel time-division demultiplexer: the receive end of the 4:1 slot-rotating serial link, where one selected channel value is driven per slot. It samples one W-bit value per strobe, aligns to a frame-sync marker on slot 0, and tracks frame lock. Each complete frame is published as four parallel channel registers with a one-cycle valid pulse. It sits after the link input register and feeds channel-wise consumers.

---
 rtl/tdm_demux_4_pkg.sv | 16 +
 rtl/tdm_demux_4_frame_fsm.sv | 94 +++++++++
 rtl/tdm_demux_4.sv | 77 +++++++
 3 files changed

// File: rtl/tdm_demux_4_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);

  typedef logic [1:0] state_t;

  localparam state_t HUNT = 2'd0;
  localparam state_t SYNC = 2'd1;
  localparam state_t LOCK = 2'd2;

  localparam logic [SLOT_W-1:0] FIRST_DATA_SLOT = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] LAST_SLOT       = SLOT_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_demux_4_frame_fsm.sv
// Frame alignment FSM: state, slot counter, good-frame counter and SYNC_ERR.
// Emits shadow write enable/index and a publish strobe for the datapath.
module tdm_frame_fsm
  import tdm_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              FS,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err,
  output logic              shadow_we,
  output logic [SLOT_W-1:0] shadow_idx,
  output logic              publish,
  output logic              lock_lost
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_nxt;
  logic [3:0]        count, count_nxt, count_inc;
  logic              err;

  assign count_inc = count + 4'd1;

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    count_nxt  = count;
    err        = 1'b0;
    shadow_we  = 1'b0;
    shadow_idx = '0;
    publish    = 1'b0;
    if (EN) begin
      if (state == HUNT) begin
        if (FS) begin
          shadow_we = 1'b1;
          slot_nxt  = FIRST_DATA_SLOT;
          count_nxt = '0;
          state_nxt = SYNC;
        end
      end else if (FS) begin
        // FS always restarts the frame in slot 0; off slot 0 it is also an error
        shadow_we = 1'b1;
        slot_nxt  = FIRST_DATA_SLOT;
        if (slot != '0) begin
          err       = 1'b1;
          count_nxt = '0;
          state_nxt = SYNC;
        end
      end else if (slot == '0) begin
        err       = 1'b1;
        count_nxt = '0;
        slot_nxt  = '0;
        state_nxt = HUNT;
      end else if (slot != LAST_SLOT) begin
        shadow_we  = 1'b1;
        shadow_idx = slot;
        slot_nxt   = slot + FIRST_DATA_SLOT;
      end else begin
        slot_nxt = '0;
        if (state == LOCK) begin
          publish = 1'b1;
        end else begin
          count_nxt = count_inc;
          if (count_inc == 4'(LOCK_FRAMES)) begin
            state_nxt = LOCK;
            publish   = 1'b1;
          end
        end
      end
    end
  end

  assign locked    = (state == LOCK);
  assign lock_lost = err && (state == LOCK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= HUNT;
      slot     <= '0;
      count    <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      count    <= count_nxt;
      sync_err <= err;
    end
  end

endmodule

// File: rtl/tdm_demux_4.sv
// Four-channel TDM demultiplexer top: shadow registers and published Q registers.
// Define TDM_DEMUX_HOLD_EN to keep Q0..Q3 when lock is lost instead of clearing them.
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int unsigned W           = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         FS,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q0,
  output logic [W-1:0] Q1,
  output logic [W-1:0] Q2,
  output logic [W-1:0] Q3,
  output logic         VALID,
  output logic [1:0]   SLOT,
  output logic         LOCKED,
  output logic         SYNC_ERR
);

  // Slot 3 is never shadowed: it is loaded into Q3 directly on the completing edge
  logic [W-1:0]      shadow [NUM_SLOTS-1];
  logic              shadow_we;
  logic [SLOT_W-1:0] shadow_idx;
  logic              publish;
  logic              lock_lost;

  tdm_frame_fsm #(
    .LOCK_FRAMES(LOCK_FRAMES)
  ) u_fsm (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .FS        (FS),
    .slot      (SLOT),
    .locked    (LOCKED),
    .sync_err  (SYNC_ERR),
    .shadow_we (shadow_we),
    .shadow_idx(shadow_idx),
    .publish   (publish),
    .lock_lost (lock_lost)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
      Q0    <= '0;
      Q1    <= '0;
      Q2    <= '0;
      Q3    <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= publish;
      for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
        if (shadow_we && shadow_idx == SLOT_W'(i)) shadow[i] <= D;
      end
      if (publish) begin
        Q0 <= shadow[0];
        Q1 <= shadow[1];
        Q2 <= shadow[2];
        Q3 <= D;
      end
`ifndef TDM_DEMUX_HOLD_EN
      else if (lock_lost) begin
        Q0 <= '0;
        Q1 <= '0;
        Q2 <= '0;
        Q3 <= '0;
      end
`endif
    end
  end

endmodule
